// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers for both write and read sides: pointer type, skid states, Gray decode.
// Pure declarations; no latency or backpressure of its own.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int PTR_W_MAX       = 32;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_e;

    // Bits at or above 'width' are forced to zero, so any pointer up to PTR_W_MAX bits decodes correctly.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray, input int width);
        logic [PTR_W_MAX-1:0] bin;
        logic                 acc;
        bin = '0;
        acc = 1'b0;
        for (int i = PTR_W_MAX - 1; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ingress_if.sv
// Write-ingress bundle: producer stream, write-pointer block strobe/data, synchronized read pointer, level.
// Signal bundle only; latency and backpressure are set by the modules on either side.
interface fifo_wr_ingress_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  wfull;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  walmost_full;

    modport master (
        output s_valid, s_data, wfull, wq2_rptr,
        input  s_ready, winc, wdata, wlevel, walmost_full
    );

    modport slave (
        input  s_valid, s_data, wfull, wq2_rptr,
        output s_ready, winc, wdata, wlevel, walmost_full
    );

endinterface

// File: rtl/fifo_wr_ingress_skid_buf2.sv
// Two-entry skid buffer; word accepted at edge N is offered on out_vld in cycle N+1.
// in_rdy is registered; one extra word lands in the skid register when out_rdy drops, then in_rdy falls.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_dat
);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  rdy_q, rdy_d;
    logic                  accept;
    logic                  pop;

    assign accept  = in_vld & rdy_q;
    assign out_vld = (state_q != SKID_EMPTY);
    assign pop     = out_vld & out_rdy;
    assign in_rdy  = rdy_q;
    assign out_dat = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_d   = in_dat;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && pop) begin
                    out_d = in_dat;
                end else if (accept) begin
                    skid_d  = in_dat;
                    state_d = SKID_TWO;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // rdy_q is low in this state, so only the drain path exists.
                if (pop) begin
                    out_d   = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        rdy_d = (state_d != SKID_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: rtl/fifo_wr_ingress.sv
// Async-FIFO write ingress: skid-buffered producer stream to winc/wdata; level/almost-full when FIFO_WR_LEVEL_EN.
// Word shows on winc one cycle after accept; wfull holds the output word and s_ready drops after one skid word.
module fifo_wr_ingress
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
    input logic               wclk,
    input logic               wrst_n,
    fifo_wr_ingress_if.slave  bus
);

    typedef logic [ADDR_WIDTH:0] wptr_t;

    logic out_vld;
    logic out_rdy;

    assign out_rdy  = ~bus.wfull;
    assign bus.winc = out_vld & out_rdy;

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (wclk),
        .rst_n   (wrst_n),
        .in_vld  (bus.s_valid),
        .in_rdy  (bus.s_ready),
        .in_dat  (bus.s_data),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (bus.wdata)
    );

`ifdef FIFO_WR_LEVEL_EN
    localparam wptr_t AFULL_LVL = wptr_t'(AFULL_THRESH);

    wptr_t wbin_q, wbin_d;
    wptr_t rbin_q, rbin_d;
    wptr_t wlevel_q, wlevel_d;
    logic  afull_q, afull_d;

    // Current write folded in, lagged read side: the level can only over-report.
    always_comb begin
        wbin_d   = wbin_q + wptr_t'(bus.winc);
        rbin_d   = wptr_t'(gray2bin(PTR_W_MAX'(bus.wq2_rptr), ADDR_WIDTH + 1));
        wlevel_d = wbin_d - rbin_q;
        afull_d  = (wlevel_q >= AFULL_LVL);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            rbin_q   <= '0;
            wlevel_q <= '0;
            afull_q  <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            rbin_q   <= rbin_d;
            wlevel_q <= wlevel_d;
            afull_q  <= afull_d;
        end
    end

    assign bus.wlevel       = wlevel_q;
    assign bus.walmost_full = afull_q;
`else
    logic unused_cfg;
    assign unused_cfg       = ^{bus.wq2_rptr, wptr_t'(AFULL_THRESH)};
    assign bus.wlevel       = '0;
    assign bus.walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Bench for fifo_wr_ingress: default-size instance for streaming/backpressure/reset, ADDR_WIDTH=3 instance for level and wrap.
module tb_fifo_wr_ingress;

`ifdef FIFO_WR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic wclk = 1'b0;
    logic wrst_n;

    always #5 wclk = ~wclk;

    fifo_wr_ingress_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) if_a ();
    fifo_wr_ingress_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_b ();

    fifo_wr_ingress #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut_a (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (if_a.slave)
    );

    fifo_wr_ingress #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_THRESH(6)) dut_b (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (if_b.slave)
    );

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       full;
        logic       rdy;
        logic       winc;
        logic [7:0] wdata;
        int         lvl;
        logic       af;
    } vec_t;

    vec_t       tv[19];
    logic [7:0] sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_wr;
    int         n_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lv(input int x);
        return LVL_EN ? x : 0;
    endfunction

    function automatic logic [3:0] bin2gray4(input int x);
        logic [3:0] b;
        b = 4'(x);
        return b ^ (b >> 1);
    endfunction

    // One cycle on instance A, with a scoreboard tracking every accepted word to its winc.
    task automatic cyc_a(input logic v, input logic [7:0] d, input logic f);
        logic [7:0] exp_w;
        @(negedge wclk);
        if_a.s_valid = v;
        if_a.s_data  = d;
        if_a.wfull   = f;
        #1;
        if (if_a.winc) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("winc_no_entry", 32'(if_a.winc), 32'd0);
            end else begin
                exp_w = sb.pop_front();
                check("sb_wdata", 32'(if_a.wdata), 32'(exp_w));
            end
        end
        if (v && if_a.s_ready) begin
            sb.push_back(d);
            n_acc++;
        end
    endtask

    task automatic b_step(input logic v, input logic [7:0] d, input int rp, input logic ew,
                          input logic [7:0] ewd, input int el, input logic eaf, input string tag);
        @(negedge wclk);
        if_b.s_valid  = v;
        if_b.s_data   = d;
        if_b.wfull    = 1'b0;
        if_b.wq2_rptr = bin2gray4(rp);
        #1;
        check({tag, "_winc"}, 32'(if_b.winc), 32'(ew));
        if (ew) check({tag, "_wdata"}, 32'(if_b.wdata), 32'(ewd));
        check({tag, "_lvl"}, 32'(if_b.wlevel), 32'(lv(el)));
        check({tag, "_af"}, 32'(if_b.walmost_full), 32'(lv(int'(eaf))));
    endtask

    // Write 8 words with the read pointer parked at r0, then advance it by 8 (Gray) and drain the level.
    task automatic b_round(input int r0, input int base);
        int el;
        int prev;
        for (int k = 0; k <= 10; k++) begin
            el = (k == 0) ? 0 : ((k - 1 > 8) ? 8 : k - 1);
            b_step(k < 8, 8'(base + k), r0, (k >= 1 && k <= 8), 8'(base + k - 1), el, k >= 8, "b_wr");
        end
        prev = 8;
        for (int j = 1; j <= 11; j++) begin
            el = (j - 2 < 0) ? 8 : ((j - 2 > 8) ? 0 : 8 - (j - 2));
            b_step(1'b0, 8'h00, r0 + ((j > 8) ? 8 : j), 1'b0, 8'h00, el, prev >= 6, "b_rd");
            prev = el;
        end
    endtask

    initial begin
        for (int k = 0; k < 19; k++) begin
            tv[k].vld   = (k <= 15);
            tv[k].dat   = 8'(k + 1);
            tv[k].full  = 1'b0;
            tv[k].rdy   = 1'b1;
            tv[k].winc  = (k >= 1 && k <= 16);
            tv[k].wdata = (k == 0) ? 8'h00 : 8'((k > 16) ? 16 : k);
            tv[k].lvl   = (k == 0) ? 0 : ((k - 1 > 16) ? 16 : k - 1);
            tv[k].af    = 1'b0;
        end

        wrst_n        = 1'b0;
        if_a.s_valid  = 1'b0;
        if_a.s_data   = 8'h00;
        if_a.wfull    = 1'b0;
        if_a.wq2_rptr = '0;
        if_b.s_valid  = 1'b0;
        if_b.s_data   = 8'h00;
        if_b.wfull    = 1'b0;
        if_b.wq2_rptr = '0;

        // Reset: nothing accepted even with s_valid high.
        repeat (3) @(negedge wclk);
        if_a.s_valid = 1'b1;
        if_a.s_data  = 8'h55;
        #1;
        check("rst_rdy", 32'(if_a.s_ready), 32'd0);
        check("rst_winc", 32'(if_a.winc), 32'd0);
        check("rst_wdata", 32'(if_a.wdata), 32'd0);
        check("rst_lvl", 32'(if_a.wlevel), 32'd0);
        check("rst_af", 32'(if_a.walmost_full), 32'd0);
        check("rst_rdy_b", 32'(if_b.s_ready), 32'd0);
        @(negedge wclk);
        #1;
        check("rst_rdy2", 32'(if_a.s_ready), 32'd0);
        check("rst_winc2", 32'(if_a.winc), 32'd0);
        if_a.s_valid = 1'b0;
        wrst_n       = 1'b1;

        // Stream 0x01..0x10 with wfull low.
        for (int k = 0; k < 19; k++) begin
            @(negedge wclk);
            if_a.s_valid = tv[k].vld;
            if_a.s_data  = tv[k].dat;
            if_a.wfull   = tv[k].full;
            #1;
            check($sformatf("s1_rdy[%0d]", k), 32'(if_a.s_ready), 32'(tv[k].rdy));
            check($sformatf("s1_winc[%0d]", k), 32'(if_a.winc), 32'(tv[k].winc));
            if (tv[k].winc || k == 0)
                check($sformatf("s1_wdata[%0d]", k), 32'(if_a.wdata), 32'(tv[k].wdata));
            check($sformatf("s1_lvl[%0d]", k), 32'(if_a.wlevel), 32'(lv(tv[k].lvl)));
            check($sformatf("s1_af[%0d]", k), 32'(if_a.walmost_full), 32'(lv(int'(tv[k].af))));
        end

        // wfull asserted mid-stream.
        n_wr  = 0;
        n_acc = 0;
        cyc_a(1'b1, 8'hA0, 1'b0);
        check("bp_rdy0", 32'(if_a.s_ready), 32'd1);
        cyc_a(1'b1, 8'hA1, 1'b0);
        check("bp_winc1", 32'(if_a.winc), 32'd1);
        cyc_a(1'b1, 8'hA2, 1'b1);
        check("bp_winc_full", 32'(if_a.winc), 32'd0);
        check("bp_rdy_extra", 32'(if_a.s_ready), 32'd1);
        cyc_a(1'b1, 8'hA3, 1'b1);
        check("bp_rdy_drop", 32'(if_a.s_ready), 32'd0);
        check("bp_winc_hold", 32'(if_a.winc), 32'd0);
        cyc_a(1'b1, 8'hA3, 1'b1);
        check("bp_rdy_drop2", 32'(if_a.s_ready), 32'd0);
        check("bp_acc_under_full", 32'(n_acc), 32'd3);
        cyc_a(1'b1, 8'hA3, 1'b0);
        check("bp_resume_winc", 32'(if_a.winc), 32'd1);
        check("bp_resume_rdy", 32'(if_a.s_ready), 32'd0);
        cyc_a(1'b1, 8'hA3, 1'b0);
        check("bp_rdy_back", 32'(if_a.s_ready), 32'd1);
        cyc_a(1'b0, 8'h00, 1'b0);
        check("bp_last_winc", 32'(if_a.winc), 32'd1);
        cyc_a(1'b0, 8'h00, 1'b0);
        check("bp_idle_winc", 32'(if_a.winc), 32'd0);
        check("bp_wr_count", 32'(n_wr), 32'd4);
        check("bp_sb_left", 32'(sb.size()), 32'd0);
        check("bp_lvl", 32'(if_a.wlevel), 32'(lv(20)));

        // Reset while holding two words.
        cyc_a(1'b1, 8'hB0, 1'b1);
        cyc_a(1'b1, 8'hB1, 1'b1);
        check("rt_rdy_pre", 32'(if_a.s_ready), 32'd1);
        @(negedge wclk);
        wrst_n       = 1'b0;
        if_a.s_valid = 1'b0;
        #1;
        check("rt_two_rdy", 32'(if_a.s_ready), 32'd0);
        @(negedge wclk);
        if_a.wfull = 1'b0;
        #1;
        check("rt_winc", 32'(if_a.winc), 32'd0);
        check("rt_rdy", 32'(if_a.s_ready), 32'd0);
        check("rt_lvl", 32'(if_a.wlevel), 32'd0);
        check("rt_af", 32'(if_a.walmost_full), 32'd0);
        check("rt_wdata", 32'(if_a.wdata), 32'd0);
        wrst_n = 1'b1;
        sb.delete();
        n_wr = 0;
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 8'h00, 1'b0);
            check($sformatf("rt_no_stale[%0d]", i), 32'(if_a.winc), 32'd0);
        end
        cyc_a(1'b1, 8'hC0, 1'b0);
        check("rt_rdy_after", 32'(if_a.s_ready), 32'd1);
        cyc_a(1'b0, 8'h00, 1'b0);
        check("rt_new_winc", 32'(if_a.winc), 32'd1);
        cyc_a(1'b0, 8'h00, 1'b0);
        check("rt_wr_count", 32'(n_wr), 32'd1);

        // Small FIFO: level through address wrap, then a second round through full pointer wrap.
        b_round(0, 8'h40);
        b_round(8, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
